// File: rtl/sysu_74ip_pkg.sv
// rtl/sysu_74ip_pkg.sv - shared constants for the sysu 74-series IP set
package sysu_74ip_pkg;

    localparam int          DIGIT_W = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;
    localparam logic [3:0]  BCD_MIN = 4'd0;

endpackage

// File: rtl/sysu_bcd_digit.sv
// rtl/sysu_bcd_digit.sv - one BCD decade with load, step and terminal detect
module sysu_bcd_digit
    import sysu_74ip_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               step,
    input  logic               down,
    input  logic [DIGIT_W-1:0] d,
    output logic [DIGIT_W-1:0] q,
    output logic               is_term
);

    // Decade register: load wins over step; invalid codes recover to the wrap value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= BCD_MIN;
        end else if (load) begin
            q <= d;
        end else if (step) begin
            if (down) begin
                q <= (q == BCD_MIN || q > BCD_MAX) ? BCD_MAX : q - 4'd1;
            end else begin
                q <= (q >= BCD_MAX) ? BCD_MIN : q + 4'd1;
            end
        end
    end

    // Terminal value for the current direction; invalid codes never match
    assign is_term = down ? (q == BCD_MIN) : (q == BCD_MAX);

endmodule

// File: rtl/sysu_bcd_updown_counter.sv
// rtl/sysu_bcd_updown_counter.sv - multi-decade synchronous BCD up/down counter
module sysu_bcd_updown_counter
    import sysu_74ip_pkg::*;
#(
    parameter int DIGITS = 2
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en_n,
    input  logic                        load_n,
    input  logic                        down,
    input  logic [DIGIT_W*DIGITS-1:0]   d,
    output logic [DIGIT_W*DIGITS-1:0]   q,
    output logic                        max_min,
    output logic                        rco_n
);

    logic              count;
    logic [DIGITS-1:0] term;
    logic [DIGITS-1:0] step;

    assign count = ~en_n & load_n;

    genvar i;
    generate
        for (i = 0; i < DIGITS; i++) begin : g_digit
            // A decade steps only when every lower decade sits at its terminal value
            if (i == 0) begin : g_first
                assign step[i] = count;
            end else begin : g_next
                assign step[i] = step[i-1] & term[i-1];
            end

            sysu_bcd_digit u_digit (
                .clk     (clk),
                .rst_n   (rst_n),
                .load    (~load_n),
                .step    (step[i]),
                .down    (down),
                .d       (d[DIGIT_W*i +: DIGIT_W]),
                .q       (q[DIGIT_W*i +: DIGIT_W]),
                .is_term (term[i])
            );
        end
    endgenerate

    // Terminal count across all decades; ripple output qualified by enable and no load
    assign max_min = &term;
    assign rco_n   = ~(max_min & ~en_n & load_n);

endmodule

// File: tb/tb_sysu_bcd_updown_counter.sv
// tb/tb_sysu_bcd_updown_counter.sv - randomized self-checking bench with decimal reference model
module tb_sysu_bcd_updown_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_n;
    logic       load_n;
    logic       down;
    logic [7:0] d;
    logic [7:0] q;
    logic       max_min;
    logic       rco_n;
    logic [3:0] c0_q;
    logic [3:0] c1_q;
    logic       c0_mm, c0_rco_n, c1_mm, c1_rco_n;

    int errs   = 0;
    int checks = 0;
    bit chk_en = 1'b0;
    logic [7:0] m;

    always #5 clk = ~clk;

    sysu_bcd_updown_counter #(.DIGITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .en_n(en_n), .load_n(load_n), .down(down),
        .d(d), .q(q), .max_min(max_min), .rco_n(rco_n)
    );

    sysu_bcd_updown_counter #(.DIGITS(1)) c0 (
        .clk(clk), .rst_n(rst_n), .en_n(en_n), .load_n(load_n), .down(down),
        .d(d[3:0]), .q(c0_q), .max_min(c0_mm), .rco_n(c0_rco_n)
    );

    sysu_bcd_updown_counter #(.DIGITS(1)) c1 (
        .clk(clk), .rst_n(rst_n), .en_n(c0_rco_n), .load_n(load_n), .down(down),
        .d(d[7:4]), .q(c1_q), .max_min(c1_mm), .rco_n(c1_rco_n)
    );

    function automatic logic [7:0] to_bcd(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    // Next count from the decimal rules; invalid decades handled case by case
    function automatic logic [7:0] nxt(input logic [7:0] v, input logic dn);
        int lo, hi, n;
        lo = int'(v[3:0]);
        hi = int'(v[7:4]);
        if (lo <= 9 && hi <= 9) begin
            n = hi * 10 + lo;
            n = dn ? (n + 99) % 100 : (n + 1) % 100;
            return to_bcd(n);
        end
        if (lo > 9) return {v[7:4], dn ? 4'd9 : 4'd0};
        if (!dn) return (lo == 9) ? 8'h00 : {v[7:4], 4'(lo + 1)};
        return (lo == 0) ? 8'h99 : {v[7:4], 4'(lo - 1)};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)       m <= 8'h00;
        else if (!load_n) m <= d;
        else if (!en_n)   m <= nxt(m, down);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model for both the single and cascaded counters
    always @(negedge clk) begin
        if (chk_en) begin
            logic emm, erco;
            emm  = down ? (m == 8'h00) : (m == 8'h99);
            erco = !(emm && !en_n && load_n);
            chk("model_q", q, m);
            chk("model_max_min", max_min, emm);
            chk("model_rco_n", rco_n, erco);
            chk("cascade_q", {c1_q, c0_q}, m);
            chk("cascade_rco_n", c1_rco_n, erco);
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en_n = 1'b0; load_n = 1'b1; down = 1'b0; d = 8'h00;
        #2;
        chk("reset_q", q, 8'h00);
        chk("reset_mm_up", max_min, 1'b0);
        chk("reset_rco_up", rco_n, 1'b1);
        down = 1'b1;
        #1;
        chk("reset_mm_dn", max_min, 1'b1);
        chk("reset_rco_dn", rco_n, 1'b0);
        down = 1'b0;
        cyc();
        chk_en = 1'b1;
        rst_n  = 1'b1;

        for (int k = 1; k <= 100; k++) begin
            cyc();
            if (k == 9)   chk("run_09", q, 8'h09);
            if (k == 10)  chk("run_10", q, 8'h10);
            if (k == 99) begin
                chk("run_99", q, 8'h99);
                chk("run_99_rco", rco_n, 1'b0);
            end
            if (k == 100) chk("run_wrap", q, 8'h00);
        end

        load_n = 1'b0; d = 8'h01;
        cyc();
        chk("dn_load", q, 8'h01);
        load_n = 1'b1; down = 1'b1;
        chk("dn_load_rco", rco_n, 1'b1);
        cyc();
        chk("dn_00", q, 8'h00);
        chk("dn_00_rco", rco_n, 1'b0);
        cyc();
        chk("dn_99", q, 8'h99);
        chk("dn_99_rco", rco_n, 1'b1);
        cyc();
        chk("dn_98", q, 8'h98);

        load_n = 1'b0; en_n = 1'b0; down = 1'b0; d = 8'h47;
        cyc();
        chk("prio_47", q, 8'h47);
        load_n = 1'b1; en_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("hold_47", q, 8'h47);
        end

        load_n = 1'b0; en_n = 1'b0; d = 8'h1C;
        cyc();
        load_n = 1'b1;
        cyc();
        chk("inv_up", q, 8'h10);
        load_n = 1'b0; d = 8'hF5;
        cyc();
        load_n = 1'b1; down = 1'b1;
        cyc();
        chk("inv_dn", q, 8'hF4);

        load_n = 1'b0; down = 1'b0; d = 8'h63;
        cyc();
        chk("pre_async", q, 8'h63);
        load_n = 1'b1; en_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_clr", q, 8'h00);
        cyc();
        rst_n = 1'b1; en_n = 1'b0;
        cyc();
        chk("post_rst", q, 8'h01);

        down = 1'b0;
        for (int k = 0; k < 250; k++) cyc();
        down = 1'b1;
        for (int k = 0; k < 250; k++) cyc();

        for (int k = 0; k < 600; k++) begin
            down   = 1'($urandom_range(0, 1));
            en_n   = ($urandom_range(0, 3) == 0);
            load_n = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 3) == 0) d = 8'($urandom_range(0, 255));
            else                           d = to_bcd(int'($urandom_range(0, 99)));
            cyc();
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
